// File: rtl/orb_stage_sequencer.sv
// ORB front-end sequencer: loads the parameter bank, then runs
// convolution, FAST and circle overlay in order under a per-stage watchdog.
module orb_stage_sequencer #(
   parameter int NUM_PARAMS  = 8,
   parameter int PARAM_DEPTH = 8,
   parameter int TIMEOUT     = 640000
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              new_trans,
   output logic [$clog2(NUM_PARAMS)-1:0]     addr_params,
   output logic                              ren_params,
   input  logic [PARAM_DEPTH-1:0]            rdat_params,
   output logic [NUM_PARAMS*PARAM_DEPTH-1:0] params_out,
   output logic                              conv_start,
   input  logic                              conv_done,
   output logic                              fast_start,
   input  logic                              fast_done,
   output logic                              circle_start,
   input  logic                              circle_done,
   output logic                              busy,
   output logic                              img_done,
   output logic                              timeout_err,
   output logic [2:0]                        stage
);

   localparam int AW = $clog2(NUM_PARAMS);
   localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_PARAMS - 1);
   localparam logic [WW-1:0] WD_LIMIT =
      (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;
   localparam bit WD_ON = (TIMEOUT > 0);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_LOAD_LAST = 3'd2,
      S_CONV      = 3'd3,
      S_FAST      = 3'd4,
      S_CIRCLE    = 3'd5,
      S_DONE      = 3'd6
   } state_t;

   state_t                            state_q, state_d;
   logic [AW-1:0]                     cnt_q, cnt_d;
   logic [WW-1:0]                     wd_q, wd_d;
   logic                              first_q, first_d;
   logic                              err_q, err_d;
   logic [NUM_PARAMS*PARAM_DEPTH-1:0] par_q, par_d;

   logic          wr_en;
   logic [AW-1:0] wr_idx;
   logic          stage_done;
   logic          wd_expire;
   state_t        next_stage;

   // Next-state, load counter, watchdog and error flag
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wd_d       = wd_q;
      first_d    = 1'b0;
      err_d      = err_q;
      wr_en      = 1'b0;
      wr_idx     = cnt_q - 1'b1;
      stage_done = 1'b0;
      next_stage = S_DONE;
      unique case (state_q)
         S_CONV: begin
            stage_done = conv_done;
            next_stage = S_FAST;
         end
         S_FAST: begin
            stage_done = fast_done;
            next_stage = S_CIRCLE;
         end
         S_CIRCLE: begin
            stage_done = circle_done;
            next_stage = S_DONE;
         end
         default: begin
            stage_done = 1'b0;
            next_stage = S_DONE;
         end
      endcase
      wd_expire = WD_ON && (wd_q == WD_LIMIT);
      case (state_q)
         S_IDLE, S_DONE: begin
            if (new_trans) begin
               state_d = S_LOAD;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         S_LOAD: begin
            // Read data for address k arrives during cycle k+1
            wr_en = (cnt_q != '0);
            if (cnt_q == LAST_IDX) begin
               state_d = S_LOAD_LAST;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_LOAD_LAST: begin
            wr_en   = 1'b1;
            wr_idx  = LAST_IDX;
            cnt_d   = '0;
            state_d = S_CONV;
            first_d = 1'b1;
            wd_d    = '0;
         end
         S_CONV, S_FAST, S_CIRCLE: begin
            wd_d = wd_q + 1'b1;
            if (!first_q && stage_done) begin
               state_d = next_stage;
               first_d = (next_stage != S_DONE);
               wd_d    = '0;
            end else if (wd_expire) begin
               state_d = S_DONE;
               err_d   = 1'b1;
               wd_d    = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Parameter bank write port
   always_comb begin
      par_d = par_q;
      for (int i = 0; i < NUM_PARAMS; i++) begin
         if (wr_en && (wr_idx == AW'(i))) begin
            par_d[i*PARAM_DEPTH +: PARAM_DEPTH] = rdat_params;
         end
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wd_q    <= '0;
         first_q <= 1'b0;
         err_q   <= 1'b0;
         par_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wd_q    <= wd_d;
         first_q <= first_d;
         err_q   <= err_d;
         par_q   <= par_d;
      end
   end

   assign stage        = state_q;
   assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
   assign img_done     = (state_q == S_DONE);
   assign ren_params   = (state_q == S_LOAD);
   assign addr_params  = ren_params ? cnt_q : '0;
   assign conv_start   = (state_q == S_CONV) && first_q;
   assign fast_start   = (state_q == S_FAST) && first_q;
   assign circle_start = (state_q == S_CIRCLE) && first_q;
   assign timeout_err  = err_q;
   assign params_out   = par_q;

endmodule
